// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the core's data-memory port. Each access decodes either to a
//   word-addressed RAM with byte-lane writes or to a small peripheral register
//   file (LED, free-running timer, compare, IRQ status). It also drives the
//   core's timer interrupt line. One access per cycle, no wait states.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   memen      access valid this cycle
//   memwrite   byte-lane write enables (0000 with memen = read)
//   addr       byte address, bits [1:0] ignored
//   writedata  lane-aligned store data
//   readdata   registered load data, valid the cycle after the request
//   int_o      interrupt lines; only bit IRQ_BIT carries the timer-match flag
//   led        LED register contents
module dmem_responder #(
  parameter int          RAM_AW      = 14,
  parameter logic [15:0] PERIPH_BASE = 16'hBFAF,
  parameter int          IRQ_BIT     = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memen,
  input  logic [3:0]  memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [5:0]  int_o,
  output logic [15:0] led
);

  localparam logic [13:0] OFF_LED     = 14'h0000;
  localparam logic [13:0] OFF_TIMER   = 14'h0001;
  localparam logic [13:0] OFF_COMPARE = 14'h0002;
  localparam logic [13:0] OFF_STATUS  = 14'h0003;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic              periph;
  logic [13:0]       periph_off;
  logic              wr_en;
  logic              rd_en;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr;

  assign periph      = (addr[31:16] == PERIPH_BASE);
  assign periph_off  = addr[15:2];
  assign wr_en       = memen & (|memwrite);
  assign rd_en       = memen & (memwrite == 4'b0000);
  assign ram_idx     = addr[RAM_AW+1:2];
  assign unused_addr = ^addr[1:0];

  // A store that is in flight when reset asserts must not land in the RAM,
  // even though the RAM array itself has no reset.
  assign ram_we = wr_en & ~periph & ~rst;

  logic [31:0] ram_q [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (memwrite[i]) ram_q[ram_idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  logic [31:0] readdata_q, readdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;
  logic [31:0] periph_rdata;

  always_comb begin
    periph_rdata = 32'h0;
    case (periph_off)
      OFF_LED:     periph_rdata = {16'h0, led_q};
      OFF_TIMER:   periph_rdata = timer_q;
      OFF_COMPARE: periph_rdata = compare_q;
      OFF_STATUS:  periph_rdata = {31'h0, pending_q};
      default:     periph_rdata = 32'h0;
    endcase
  end

  always_comb begin
    readdata_d = readdata_q;
    led_d      = led_q;
    timer_d    = timer_q + 32'd1;
    compare_d  = compare_q;
    pending_d  = pending_q;

    if (wr_en && periph) begin
      case (periph_off)
        OFF_LED: begin
          if (memwrite[0]) led_d[7:0]  = writedata[7:0];
          if (memwrite[1]) led_d[15:8] = writedata[15:8];
        end
        // Unwritten bytes keep the value seen at this edge, not the incremented one.
        OFF_TIMER:   timer_d   = lane_merge(timer_q, writedata, memwrite);
        OFF_COMPARE: compare_d = lane_merge(compare_q, writedata, memwrite);
        OFF_STATUS: begin
          if (memwrite[0] && writedata[0]) pending_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Applied after the clear so a same-cycle match keeps the flag set.
    if ((compare_q != 32'h0) && (timer_q == compare_q)) pending_d = 1'b1;

    if (rd_en) readdata_d = periph ? periph_rdata : ram_q[ram_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= 32'h0;
      led_q      <= 16'h0;
      timer_q    <= 32'h0;
      compare_q  <= 32'h0;
      pending_q  <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      led_q      <= led_d;
      timer_q    <= timer_d;
      compare_q  <= compare_d;
      pending_q  <= pending_d;
    end
  end

  always_comb begin
    int_o          = 6'b0;
    int_o[IRQ_BIT] = pending_q;
  end

  assign readdata = readdata_q;
  assign led      = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam logic [15:0] PB = 16'hBFAF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memen = 1'b0;
  logic [3:0]  memwrite = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [5:0]  int_o;
  logic [15:0] led;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_mem [int];
  logic [15:0] m_led = 16'h0;
  logic [31:0] m_timer = 32'h0;
  logic [31:0] m_cmp = 32'h0;
  logic [31:0] m_rd = 32'h0;
  logic        m_pend = 1'b0;

  dmem_responder dut (
    .clk(clk), .rst(rst), .memen(memen), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .int_o(int_o), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] apply_lanes(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [5:0] exp_int();
    return m_pend ? 6'b100000 : 6'b000000;
  endfunction

  function automatic logic [31:0] paddr(input logic [15:0] off);
    return {PB, off};
  endfunction

  // One clock of stimulus plus the model's view of that clock edge.
  task automatic step(input logic en, input logic [3:0] we,
                      input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] n_rd, n_timer, n_cmp, tmp;
    logic [15:0] n_led, off;
    logic        n_pend, is_p;
    int          idx;
    memen = en; memwrite = we; addr = a; writedata = wd;
    is_p = (a[31:16] == PB);
    off  = {a[15:2], 2'b00};
    idx  = int'(a[15:2]);
    n_rd = m_rd; n_led = m_led; n_timer = m_timer + 32'd1; n_cmp = m_cmp; n_pend = m_pend;
    if (en && we == 4'h0) begin
      if (is_p) begin
        case (off)
          16'h0000: n_rd = {16'h0, m_led};
          16'h0004: n_rd = m_timer;
          16'h0008: n_rd = m_cmp;
          16'h000C: n_rd = {31'h0, m_pend};
          default:  n_rd = 32'h0;
        endcase
      end else begin
        n_rd = m_mem.exists(idx) ? m_mem[idx] : 32'hx;
      end
    end
    if (en && we != 4'h0) begin
      if (is_p) begin
        case (off)
          16'h0000: begin tmp = apply_lanes({16'h0, m_led}, wd, we); n_led = tmp[15:0]; end
          16'h0004: n_timer = apply_lanes(m_timer, wd, we);
          16'h0008: n_cmp = apply_lanes(m_cmp, wd, we);
          16'h000C: if (we[0] && wd[0]) n_pend = 1'b0;
          default: ;
        endcase
      end else begin
        m_mem[idx] = apply_lanes(m_mem.exists(idx) ? m_mem[idx] : 32'h0, wd, we);
      end
    end
    if (m_cmp != 32'h0 && m_timer == m_cmp) n_pend = 1'b1;
    @(posedge clk); #1;
    m_rd = n_rd; m_led = n_led; m_timer = n_timer; m_cmp = n_cmp; m_pend = n_pend;
    memen = 1'b0; memwrite = 4'h0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", readdata, 32'h0); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    checks++; if (int_o !== 6'h0) begin failures++; $display("FAIL reset_int got=%b exp=%b", int_o, 6'h0); end
    rst = 1'b0;
    step(1'b1, 4'h0, paddr(16'h0004), 32'h0);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_timer_read got=%h exp=%h", readdata, 32'h0); end
  endtask

  task automatic test_ram();
    step(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    step(1'b1, 4'hF, 32'h0000_0014, 32'hCAFE_F00D);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (readdata !== 32'h1122_3344) begin failures++; $display("FAIL ram_full_word got=%h exp=%h", readdata, 32'h1122_3344); end
    step(1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00);
    checks++; if (readdata !== 32'h1122_3344) begin failures++; $display("FAIL ram_hold_on_write got=%h exp=%h", readdata, 32'h1122_3344); end
    step(1'b1, 4'h0, 32'h0000_0013, 32'h0);
    checks++; if (readdata !== 32'h1122_AB44) begin failures++; $display("FAIL ram_byte_lane got=%h exp=%h", readdata, 32'h1122_AB44); end
    step(1'b1, 4'h0, 32'h0000_0014, 32'h0);
    checks++; if (readdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_neighbour got=%h exp=%h", readdata, 32'hCAFE_F00D); end
    step(1'b1, 4'h0, 32'h0001_0010, 32'h0);
    checks++; if (readdata !== 32'h1122_AB44) begin failures++; $display("FAIL ram_alias got=%h exp=%h", readdata, 32'h1122_AB44); end
    step(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (readdata !== 32'h1122_AB44) begin failures++; $display("FAIL ram_hold_idle got=%h exp=%h", readdata, 32'h1122_AB44); end
  endtask

  task automatic test_led();
    step(1'b1, 4'hF, paddr(16'h0000), 32'hFFFF_5A5A);
    checks++; if (led !== 16'h5A5A) begin failures++; $display("FAIL led_write got=%h exp=%h", led, 16'h5A5A); end
    step(1'b1, 4'h0, paddr(16'h0000), 32'h0);
    checks++; if (readdata !== 32'h0000_5A5A) begin failures++; $display("FAIL led_read got=%h exp=%h", readdata, 32'h0000_5A5A); end
    step(1'b1, 4'h0, paddr(16'h0040), 32'h0);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", readdata, 32'h0); end
    checks++; if (led !== 16'h5A5A) begin failures++; $display("FAIL unmapped_no_change got=%h exp=%h", led, 16'h5A5A); end
    step(1'b1, 4'hF, paddr(16'h0040), 32'h1234_5678);
    step(1'b1, 4'b0010, paddr(16'h0000), 32'h0000_C300);
    checks++; if (led !== 16'hC35A) begin failures++; $display("FAIL led_partial got=%h exp=%h", led, 16'hC35A); end
  endtask

  task automatic test_timer_irq();
    int rise;
    step(1'b1, 4'hF, paddr(16'h0004), 32'h0000_1000);
    step(1'b1, 4'hF, paddr(16'h0008), 32'h0000_0020);
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    step(1'b1, 4'hF, paddr(16'h0004), 32'h0000_0500);
    step(1'b1, 4'h0, paddr(16'h0004), 32'h0);
    checks++; if (readdata !== 32'h0000_0500) begin failures++; $display("FAIL timer_pre_increment got=%h exp=%h", readdata, 32'h0000_0500); end
    step(1'b1, 4'h0, paddr(16'h0008), 32'h0);
    checks++; if (readdata !== 32'h0000_0020) begin failures++; $display("FAIL compare_read got=%h exp=%h", readdata, 32'h0000_0020); end
    step(1'b1, 4'hF, paddr(16'h0004), 32'h0000_0010);
    rise = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      if (rise == 0 && int_o[5] === 1'b1) rise = k;
    end
    checks++; if (rise != 17) begin failures++; $display("FAIL irq_latency got=%0d exp=%0d", rise, 17); end
    checks++; if (int_o !== 6'b100000) begin failures++; $display("FAIL irq_sticky got=%b exp=%b", int_o, 6'b100000); end
    step(1'b1, 4'h0, paddr(16'h000C), 32'h0);
    checks++; if (readdata !== 32'h1) begin failures++; $display("FAIL status_read got=%h exp=%h", readdata, 32'h1); end
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    checks++; if (int_o !== 6'b000000) begin failures++; $display("FAIL irq_clear got=%b exp=%b", int_o, 6'b000000); end
  endtask

  task automatic test_match_clear();
    int guard;
    int seen;
    step(1'b1, 4'hF, paddr(16'h0008), 32'h0000_0080);
    step(1'b1, 4'hF, paddr(16'h0004), 32'h0000_007A);
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    guard = 0;
    while (m_timer != 32'h80 && guard < 20) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      guard++;
    end
    checks++; if (guard >= 20) begin failures++; $display("FAIL match_setup_timeout got=%0d exp<%0d", guard, 20); end
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    checks++; if (int_o !== 6'b100000) begin failures++; $display("FAIL set_beats_clear got=%b exp=%b", int_o, 6'b100000); end
    step(1'b1, 4'hF, paddr(16'h0008), 32'h0);
    checks++; if (int_o !== 6'b100000) begin failures++; $display("FAIL compare_write_keeps got=%b exp=%b", int_o, 6'b100000); end
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    step(1'b1, 4'hF, paddr(16'h0004), 32'hFFFF_FFF8);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      if (int_o !== 6'b0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL compare_zero_irq got=%0d exp=%0d", seen, 0); end
    step(1'b1, 4'h0, paddr(16'h0004), 32'h0);
    checks++; if (readdata !== m_rd) begin failures++; $display("FAIL timer_wrap got=%h exp=%h", readdata, m_rd); end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic [3:0]  we;
    logic [15:0] hi;
    logic [15:0] offs [6];
    int          kind;
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0040, 16'h0010};
    for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 32'h0000_0400 + 32'(i * 4), $urandom);
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      wd = $urandom;
      if (kind < 5) begin
        hi = 16'($urandom);
        if (hi == PB) hi = 16'h0;
        a = {hi, 16'h0400 + 16'($urandom_range(0, 7) * 4)} | 32'($urandom_range(0, 3));
      end else begin
        a = paddr(offs[$urandom_range(0, 5)]) | 32'($urandom_range(0, 3));
        if (a[15:2] == 14'h2 && we != 4'h0) wd = m_timer + 32'($urandom_range(2, 12));
      end
      step(kind != 9, we, a, wd);
      checks++; if (readdata !== m_rd) begin failures++; $display("FAIL rand_readdata n=%0d got=%h exp=%h", n, readdata, m_rd); end
      checks++; if (led !== m_led) begin failures++; $display("FAIL rand_led n=%0d got=%h exp=%h", n, led, m_led); end
      checks++; if (int_o !== exp_int()) begin failures++; $display("FAIL rand_int n=%0d got=%b exp=%b", n, int_o, exp_int()); end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    step(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    step(1'b1, 4'hF, paddr(16'h0000), 32'h0000_1234);
    step(1'b1, 4'hF, paddr(16'h000C), 32'h0000_0001);
    step(1'b1, 4'hF, paddr(16'h0008), 32'h0000_0040);
    step(1'b1, 4'hF, paddr(16'h0004), 32'h0000_003F);
    guard = 0;
    while (m_pend !== 1'b1 && guard < 10) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      guard++;
    end
    step(1'b1, 4'h0, paddr(16'h0000), 32'h0);
    checks++; if (int_o !== 6'b100000 || led !== 16'h1234 || readdata !== 32'h1234) begin
      failures++; $display("FAIL pre_reset_state got=%b/%h/%h exp=%b/%h/%h", int_o, led, readdata, 6'b100000, 16'h1234, 32'h1234);
    end
    memen = 1'b1; memwrite = 4'hF; addr = 32'h0000_0010; writedata = 32'hDEAD_BEEF;
    #3 rst = 1'b1;
    #1;
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL async_reset_readdata got=%h exp=%h", readdata, 32'h0); end
    checks++; if (led !== 16'h0) begin failures++; $display("FAIL async_reset_led got=%h exp=%h", led, 16'h0); end
    checks++; if (int_o !== 6'h0) begin failures++; $display("FAIL async_reset_int got=%b exp=%b", int_o, 6'h0); end
    @(posedge clk); #1;
    rst = 1'b0; memen = 1'b0; memwrite = 4'h0;
    m_rd = 32'h0; m_led = 16'h0; m_timer = 32'h0; m_cmp = 32'h0; m_pend = 1'b0;
    step(1'b1, 4'h0, paddr(16'h0004), 32'h0);
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_timer_zero got=%h exp=%h", readdata, 32'h0); end
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    checks++; if (readdata !== 32'h1122_3344) begin failures++; $display("FAIL ram_survives_reset got=%h exp=%h", readdata, 32'h1122_3344); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_timer_irq();
    test_match_clear();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
